// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : handshaked, registered ALU with persistent carry and an iterative
//           shift-add multiplier.
//
// The block takes one operation at a time. Single-cycle operations return a
// result one cycle after they are accepted. MUL returns WIDTH+1 cycles after
// it is accepted. The result and flags are then held until the consumer
// takes them.
//
// Parameters
//   WIDTH      operand/result width (>= 4)
//   OPW        opcode width (>= 5)
//
// Optional build macro
//   ALU_SHIFT_EN  enables SHL(16) / SHR(17) / SRA(18). When it is undefined
//                 these opcodes decode as illegal and no shifter is built.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation request       in_ready  block can accept this cycle
//   opcode     operation select        a, b      operands
//   out_valid  result/flags valid      out_ready consumer takes result
//   result     result (low product half for MUL)
//   result_hi  high product half for MUL, 0 otherwise
//   flags      {ERR, V, C, N, Z}
//   carry_q    stored carry, consumed by ADC/SBB
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int OPW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [4:0]       flags,
   output logic             carry_q
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
   localparam logic [OPW-1:0] OP_ADC  = OPW'(1);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
   localparam logic [OPW-1:0] OP_SBB  = OPW'(3);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(4);
   localparam logic [OPW-1:0] OP_AND  = OPW'(8);
   localparam logic [OPW-1:0] OP_OR   = OPW'(9);
   localparam logic [OPW-1:0] OP_XOR  = OPW'(10);
   localparam logic [OPW-1:0] OP_NAND = OPW'(11);
   localparam logic [OPW-1:0] OP_NOR  = OPW'(12);
   localparam logic [OPW-1:0] OP_XNOR = OPW'(13);
   localparam logic [OPW-1:0] OP_NOT  = OPW'(14);
   localparam logic [OPW-1:0] OP_NEG  = OPW'(15);
`ifdef ALU_SHIFT_EN
   localparam logic [OPW-1:0] OP_SHL  = OPW'(16);
   localparam logic [OPW-1:0] OP_SHR  = OPW'(17);
   localparam logic [OPW-1:0] OP_SRA  = OPW'(18);
   localparam int             SAW     = $clog2(WIDTH);
`endif

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_BUSY = 2'd1,
      HOLD     = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    result_q, result_d;
   logic [WIDTH-1:0]    result_hi_q, result_hi_d;
   logic [4:0]          flags_q, flags_d;
   logic                carry_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]    mcand_q, mcand_d;
   // Product register: the upper half accumulates, the lower half starts as
   // the multiplier and is shifted out one bit per step.
   logic [2*WIDTH-1:0]  prod_q, prod_d;

   logic accept;

   // ---------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------
   assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == HOLD);

   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign flags     = flags_q;

   // ---------------------------------------------------------------------
   // Single-cycle datapath. All add/subtract forms, including NEG, share
   // one adder: x + y + cin.
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] ax, bx;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v, alu_err, alu_arith;

`ifdef ALU_SHIFT_EN
   logic [SAW-1:0]   amt;
   logic [WIDTH:0]   shl_w, shr_w, sra_w;
   // A guard bit on the far side of each shift catches the last bit that
   // was shifted out. With an amount of 0 that bit stays 0.
   assign amt   = b[SAW-1:0];
   assign shl_w = {1'b0, a} << amt;
   assign shr_w = {a, 1'b0} >> amt;
   assign sra_w = $signed({a, 1'b0}) >>> amt;
`endif

   always_comb begin
      ax = a;
      bx = b;
      cin = 1'b0;
      unique case (opcode)
         OP_ADC: cin = carry_q;
         OP_SUB: begin bx = ~b; cin = 1'b1;    end
         OP_SBB: begin bx = ~b; cin = carry_q; end
         OP_NEG: begin ax = ~a; bx = '0; cin = 1'b1; end
         default: ;
      endcase
   end

   assign sum = {1'b0, ax} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};

   always_comb begin
      alu_res   = '0;
      alu_c     = 1'b0;
      alu_v     = 1'b0;
      alu_err   = 1'b0;
      alu_arith = 1'b0;
      case (opcode)
         OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_NEG: begin
            alu_res   = sum[WIDTH-1:0];
            alu_c     = sum[WIDTH];
            // Signed overflow: the adder inputs share a sign and the sum's
            // sign differs from it.
            alu_v     = (ax[WIDTH-1] == bx[WIDTH-1]) &&
                        (sum[WIDTH-1] != ax[WIDTH-1]);
            alu_arith = (opcode != OP_NEG);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NAND: alu_res = ~(a & b);
         OP_NOR:  alu_res = ~(a | b);
         OP_XNOR: alu_res = ~(a ^ b);
         OP_NOT:  alu_res = ~a;
`ifdef ALU_SHIFT_EN
         OP_SHL: begin alu_res = shl_w[WIDTH-1:0]; alu_c = shl_w[WIDTH]; end
         OP_SHR: begin alu_res = shr_w[WIDTH:1];   alu_c = shr_w[0];     end
         OP_SRA: begin alu_res = sra_w[WIDTH:1];   alu_c = sra_w[0];     end
`endif
         // An illegal opcode, and MUL on this path, give a zero result with
         // ERR set. MUL never takes this value: it goes through MUL_BUSY.
         default: alu_err = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------
   // One multiplier step
   // ---------------------------------------------------------------------
   logic [WIDTH:0]       psum;
   logic [2*WIDTH-1:0]   prod_step;

   assign psum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                      {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
   assign prod_step = {psum, prod_q[WIDTH-1:1]};

   // ---------------------------------------------------------------------
   // FSM: next-state and datapath update
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      flags_d     = flags_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      prod_d      = prod_q;
      case (state_q)
         IDLE, HOLD: begin
            if (accept) begin
               if (opcode == OP_MUL) begin
                  state_d = MUL_BUSY;
                  mcand_d = a;
                  prod_d  = {{WIDTH{1'b0}}, b};
                  cnt_d   = '0;
               end else begin
                  state_d     = HOLD;
                  result_d    = alu_res;
                  result_hi_d = '0;
                  flags_d     = {alu_err, alu_v, alu_c, alu_res[WIDTH-1],
                                 (alu_res == '0)};
                  if (alu_arith) carry_d = alu_c;
               end
            end else if (state_q == HOLD && out_ready) begin
               state_d = IDLE;
            end
         end
         MUL_BUSY: begin
            prod_d = prod_step;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d     = HOLD;
               result_d    = prod_step[WIDTH-1:0];
               result_hi_d = prod_step[2*WIDTH-1:WIDTH];
               flags_d     = {1'b0, (prod_step[2*WIDTH-1:WIDTH] != '0), 1'b0,
                              prod_step[WIDTH-1], (prod_step[WIDTH-1:0] == '0)};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q    <= '0;
         result_hi_q <= '0;
         flags_q     <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         mcand_q     <= '0;
         prod_q      <= '0;
      end else begin
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         flags_q     <= flags_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         mcand_q     <= mcand_d;
         prod_q      <= prod_d;
      end
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked, registered ALU; next generation of the team's 32-bit one-hot-decoded ALU.
- Sits between the register-read stage and the writeback bus. Takes one operation at a time and returns a registered result with flags.
- Adds a persistent carry flag for ADC/SBB chains, an iterative shift-add multiplier and valid/ready flow control.

Parameters:
WIDTH, 32, operand and result width in bits (>=4)
OPW, 5, opcode width in bits (fixed encoding below; must be >=5)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation this cycle
opcode  input  OPW  operation select
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result this cycle
result  output  WIDTH  result, low half of product for MUL
result_hi  output  WIDTH  high half of product for MUL, 0 otherwise
flags  output  5  {ERR, V, C, N, Z}
carry_q  output  1  stored carry flag, consumed by ADC/SBB

Behaviour:
- Clock and reset: one clock `clk`. `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE; out_valid=0; result=0; result_hi=0; flags=0; carry_q=0; iteration counter=0.
- Reset mid-MUL aborts the operation with no output.
- Opcodes:
  - 0 ADD: a+b
  - 1 ADC: a+b+carry_q
  - 2 SUB: a+~b+1
  - 3 SBB: a+~b+carry_q
  - 4 MUL: unsigned a*b, 2*WIDTH product
  - 8 AND, 9 OR, 10 XOR, 11 NAND, 12 NOR, 13 XNOR
  - 14 NOT: ~a
  - 15 NEG: ~a+1
  - 5-7 and 16-31 are illegal: result=0, flags={1,0,0,0,1}.
- Flags:
  - Z: result==0 (low half only for MUL).
  - N: result[WIDTH-1].
  - C: carry out of bit WIDTH-1 for ADD/ADC/SUB/SBB and NEG. SUB/SBB C=1 means no borrow.
  - V: signed overflow for ADD/ADC/SUB/SBB/NEG. For MUL, V=(result_hi!=0).
  - C=V=0 for all logic ops.
- carry_q: updated with C only when an ADD/ADC/SUB/SBB result is produced. Held otherwise.
- FSM states: IDLE, MUL_BUSY, HOLD.
  - IDLE, accept, non-MUL: result registered, state moves to HOLD, out_valid=1 on the next cycle (latency 1).
  - IDLE, accept, MUL: a and b latched, counter=0, state moves to MUL_BUSY.
  - MUL_BUSY: one shift-add step per cycle for WIDTH cycles. After the WIDTH-th step, state moves to HOLD with out_valid=1. Accept-to-out_valid latency is WIDTH+1 cycles.
  - HOLD: result and flags held stable while out_ready=0. When out_ready=1, out_valid drops next cycle unless a new operation is accepted the same cycle.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==HOLD && out_ready). Back-to-back single-cycle ops therefore sustain 1 op/clk.
  - in_ready=0 throughout MUL_BUSY. Inputs are ignored when in_ready=0.
  - opcode, a and b need only be stable during the accepting cycle.
- Simultaneous events:
  - Acceptance in HOLD with out_ready=1: the old result is retired and the new operation starts the same edge.
  - ADC/SBB use the carry_q value present at acceptance, which includes an update from the result retired that same edge.
- Arithmetic is modulo 2^WIDTH. NEG of the minimum signed value returns itself with V=1.

Optional Feature:
- Macro: ALU_SHIFT_EN.
- Defined: opcodes 16 SHL, 17 SHR (logical), 18 SRA (arithmetic) are legal. Shift amount is b[$clog2(WIDTH)-1:0]. Latency 1. C = last bit shifted out (0 if amount 0). V=0.
- Undefined: opcodes 16-18 are illegal (ERR=1), and no shifter logic is synthesised.

Test Plan (WIDTH=8):
- Reset asserted mid-MUL (cycle 3 of MUL_BUSY) -> all outputs 0, in_ready=1 immediately after rst_n rises, no spurious out_valid.
- ADD a=0xFF b=0x01, then ADC a=0x00 b=0x00, out_ready=1 -> result 0x00 flags C=1,Z=1; then result 0x01, C=0, carry_q=0.
- SUB a=0x05 b=0x07 -> result 0xFE, C=0, N=1. SBB 0x80 - 0x01 with carry_q=1 -> 0x7F, V=1, C=1.
- MUL a=0xFF b=0xFF -> out_valid exactly 9 cycles after accept, result=0x01, result_hi=0xFE, V=1; in_ready=0 for 8 cycles.
- Backpressure: AND 0xF0,0x3C with out_ready=0 for 5 cycles -> result 0x30 held stable, in_ready=0. Then out_ready=1 alongside a queued XOR -> 1 op/clk, no result lost.
- Opcode 17 -> ERR=1, Z=1 without ALU_SHIFT_EN; with it, SHR a=0x81 b=1 -> 0x40, C=1.
